// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, 16-byte lines, single outstanding fetch, 4-beat line refill.
// Define ICACHE_ASID_TAG_EN to keep the request ASID in each tag entry and require it to match on a hit.
module icache_direct #(
   parameter int LINES = 64
) (
   input  logic        clk_core,
   input  logic        reset_n,
   input  logic        fe0_read_req,
   input  logic [8:0]  fe0_read_asid,
   input  logic [29:0] fe0_read_addr,
   output logic        ic_stall,
   input  logic        fe1_stall,
   output logic        ic_valid,
   output logic [31:0] ic_data,
   output logic [29:0] ic_addr,
   input  logic        ic_flush,
   output logic        mem_req,
   output logic [27:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 28 - IDX_W;
`ifdef ICACHE_ASID_TAG_EN
   localparam int ENT_W = TAG_W + 9;
`else
   localparam int ENT_W = TAG_W;
`endif

   typedef enum logic [1:0] {IDLE, REFILL, RESP, FLUSH} state_t;

   state_t             state_q, state_d;
   logic               req_v_q;
   logic [29:0]        req_addr_q;
   logic               flush_pend_q;
   logic [IDX_W-1:0]   flush_cnt_q;
   logic [1:0]         beat_q;
   logic               accept;
   logic               hit;

   logic [LINES-1:0]   valid_q;
   logic [ENT_W-1:0]   tag_mem  [LINES];
   logic [31:0]        data_mem [LINES][4];

   logic [IDX_W-1:0]   req_idx;
   logic [1:0]         req_word;
   logic [ENT_W-1:0]   req_ent;

   assign req_idx  = req_addr_q[IDX_W+1:2];
   assign req_word = req_addr_q[1:0];

`ifdef ICACHE_ASID_TAG_EN
   logic [8:0] req_asid_q;
   always_ff @(posedge clk_core) begin
      if (accept) req_asid_q <= fe0_read_asid;
   end
   assign req_ent = {req_asid_q, req_addr_q[29:IDX_W+2]};
`else
   logic unused_asid;
   assign unused_asid = ^fe0_read_asid;
   assign req_ent     = req_addr_q[29:IDX_W+2];
`endif

   assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_ent);
   assign ic_data   = data_mem[req_idx][req_word];
   assign ic_addr   = req_addr_q;
   assign mem_addr  = req_addr_q[29:2];
   assign dbg_state = state_q;

   // An accepted request is always finished before a flush starts, so a pending
   // flush waits out a miss or a held hit and then fires.
   always_comb begin
      state_d  = state_q;
      ic_stall = 1'b1;
      ic_valid = 1'b0;
      mem_req  = 1'b0;
      accept   = 1'b0;
      case (state_q)
         IDLE: begin
            ic_stall = 1'b0;
            if (req_v_q) begin
               if (!hit) begin
                  ic_stall = 1'b1;
                  state_d  = REFILL;
               end else begin
                  ic_valid = 1'b1;
                  if (fe1_stall) ic_stall = 1'b1;
               end
            end
            if (ic_flush || flush_pend_q) begin
               ic_stall = 1'b1;
               if (!(req_v_q && (!hit || fe1_stall))) state_d = FLUSH;
            end
            accept = fe0_read_req && !ic_stall;
         end
         REFILL: begin
            mem_req = 1'b1;
            if (mem_ack && beat_q == 2'd3) state_d = RESP;
         end
         RESP: begin
            ic_valid = 1'b1;
            if (!fe1_stall) state_d = (flush_pend_q || ic_flush) ? FLUSH : IDLE;
         end
         FLUSH: begin
            if (flush_cnt_q == IDX_W'(LINES - 1)) state_d = IDLE;
         end
         default: state_d = FLUSH;
      endcase
   end

   always_ff @(posedge clk_core) begin
      if (!reset_n) begin
         state_q      <= FLUSH;
         req_v_q      <= 1'b0;
         flush_pend_q <= 1'b0;
         flush_cnt_q  <= '0;
         beat_q       <= 2'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            req_v_q    <= 1'b1;
            req_addr_q <= fe0_read_addr;
         end else if ((state_q == IDLE && req_v_q && hit && !fe1_stall) ||
                      (state_q == RESP && !fe1_stall)) begin
            req_v_q <= 1'b0;
         end
         if (state_d == FLUSH && state_q != FLUSH) flush_pend_q <= 1'b0;
         else if (ic_flush && state_q != FLUSH)    flush_pend_q <= 1'b1;
         if (state_q == FLUSH) flush_cnt_q <= flush_cnt_q + 1'b1;
         if (state_q == REFILL && mem_ack) beat_q <= beat_q + 2'd1;
      end
   end

   // Storage carries no reset; the flush walk that follows reset clears the valid bits.
   always_ff @(posedge clk_core) begin
      if (reset_n) begin
         if (state_q == REFILL && mem_ack) begin
            data_mem[req_idx][beat_q] <= mem_rdata;
            if (beat_q == 2'd3) begin
               tag_mem[req_idx] <= req_ent;
               valid_q[req_idx] <= 1'b1;
            end
         end
         if (state_q == FLUSH) valid_q[flush_cnt_q] <= 1'b0;
      end
   end

endmodule
